// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction memory controller.
package instr_mem_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BYTE_W = 8;

   // Value returned for fetches beyond the populated array.
   localparam logic [WORD_W-1:0] NOP_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2,
      RUN   = 2'd3
   } load_state_e;

endpackage

// File: rtl/instr_word_assembler.sv
// Packs the incoming byte stream into 32-bit words in the configured byte order.
module instr_word_assembler
   import instr_mem_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clear,
   input  logic              i_accept,
   input  logic [BYTE_W-1:0] i_byte,
   output logic [1:0]        o_idx,
   output logic              o_word_done_c,
   output logic [WORD_W-1:0] o_word_c,
   output logic [WORD_W-1:0] o_flush_word_c
);

   logic [WORD_W-1:0] r_shift;
   logic [1:0]        r_idx;
   logic [WORD_W-1:0] w_shift_next;

   // Shift-register contents once the current byte is folded in.
   always_comb begin
      w_shift_next = r_shift;
      if (BIG_ENDIAN) w_shift_next = {r_shift[23:0], i_byte};
      else            w_shift_next = {i_byte, r_shift[31:8]};
   end

   // Partial word aligned to its first byte, unused byte lanes zeroed.
   always_comb begin
      o_flush_word_c = '0;
      case (r_idx)
         2'd1:    o_flush_word_c = BIG_ENDIAN ? {r_shift[7:0], 24'h0}  : {24'h0, r_shift[31:24]};
         2'd2:    o_flush_word_c = BIG_ENDIAN ? {r_shift[15:0], 16'h0} : {16'h0, r_shift[31:16]};
         2'd3:    o_flush_word_c = BIG_ENDIAN ? {r_shift[23:0], 8'h0}  : {8'h0, r_shift[31:8]};
         default: o_flush_word_c = '0;
      endcase
   end

   // Byte index and shift register; a clear discards any partial word.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_idx   <= 2'd0;
         r_shift <= '0;
      end else if (i_accept) begin
         r_idx   <= 2'(r_idx + 2'd1);
         r_shift <= w_shift_next;
      end
   end

   assign o_idx         = r_idx;
   assign o_word_done_c = i_accept && (r_idx == 2'd3);
   assign o_word_c      = w_shift_next;

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory: combinational fetch port plus a byte-stream loader FSM.
module instr_mem_ctrl
   import instr_mem_pkg::*;
#(
   parameter int unsigned       ADDR_W      = 16,
   parameter int unsigned       DEPTH_WORDS = 1024,
   parameter bit                BIG_ENDIAN  = 1'b1,
   parameter logic [WORD_W-1:0] NOP_WORD    = NOP_DEFAULT
)(
   input  logic              Clock,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] InstrAddr,
   output logic [WORD_W-1:0] InstrMem,
   input  logic              LoadStart,
   input  logic [ADDR_W-1:0] LoadBase,
   input  logic              LoadValid,
   input  logic [BYTE_W-1:0] LoadData,
   input  logic              LoadLast,
   output logic              LoadReady,
   output logic              CoreRun,
   output logic              LoadError,
   output logic [15:0]       WordCount
);

   localparam int unsigned PTR_W = ADDR_W - 2;
   localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

   load_state_e       r_state, w_state_next;
   logic [PTR_W-1:0]  r_ptr, w_ptr_next;
   logic [15:0]       r_count, w_count_next;
   logic              r_error, w_error_next;
   logic              r_core_run, r_load_ready;

   logic              w_accept, w_clear, w_we, w_ptr_ok, w_fetch_ok;
   logic [WORD_W-1:0] w_wdata, w_word, w_flush_word;
   logic [PTR_W-1:0]  w_fetch_idx;
   logic [1:0]        w_idx;
   logic              w_word_done;
   logic              w_unused;

   // Byte-lane address bits carry no information for word storage.
   assign w_unused = ^{LoadBase[1:0], InstrAddr[1:0]};

   // A LoadStart in LOAD takes priority, so its same-cycle byte is dropped.
   assign w_accept = (r_state == LOAD) && LoadValid && !LoadStart;
   assign w_clear  = LoadStart && (r_state != FLUSH);
   assign w_ptr_ok = (32'(r_ptr) < DEPTH_WORDS);

   instr_word_assembler #(
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_asm (
      .i_clk          (Clock),
      .i_rst          (Reset),
      .i_clear        (w_clear),
      .i_accept       (w_accept),
      .i_byte         (LoadData),
      .o_idx          (w_idx),
      .o_word_done_c  (w_word_done),
      .o_word_c       (w_word),
      .o_flush_word_c (w_flush_word)
   );

   // Loader next-state, pointer/count/error update and array write strobe.
   always_comb begin
      w_state_next = r_state;
      w_ptr_next   = r_ptr;
      w_count_next = r_count;
      w_error_next = r_error;
      w_we         = 1'b0;
      w_wdata      = w_word;
      case (r_state)
         LOAD: begin
            if (LoadStart) begin
               w_state_next = LOAD;
               w_ptr_next   = LoadBase[ADDR_W-1:2];
               w_count_next = 16'd0;
               w_error_next = 1'b0;
            end else if (w_accept) begin
               if (w_word_done) begin
                  if (w_ptr_ok) begin
                     w_we         = 1'b1;
                     w_ptr_next   = PTR_W'(r_ptr + 1'b1);
                     w_count_next = 16'(r_count + 16'd1);
                  end else begin
                     w_error_next = 1'b1;
                  end
               end
               if (LoadLast) begin
                  if (w_idx == 2'd3) w_state_next = w_error_next ? IDLE : RUN;
                  else               w_state_next = FLUSH;
               end
            end
         end
         FLUSH: begin
            w_wdata = w_flush_word;
            if (w_ptr_ok) begin
               w_we         = 1'b1;
               w_ptr_next   = PTR_W'(r_ptr + 1'b1);
               w_count_next = 16'(r_count + 16'd1);
            end else begin
               w_error_next = 1'b1;
            end
            w_state_next = w_error_next ? IDLE : RUN;
         end
         default: begin
            if (LoadStart) begin
               w_state_next = LOAD;
               w_ptr_next   = LoadBase[ADDR_W-1:2];
               w_count_next = 16'd0;
               w_error_next = 1'b0;
            end
         end
      endcase
   end

   // Loader state and registered status outputs.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state      <= IDLE;
         r_ptr        <= '0;
         r_count      <= 16'd0;
         r_error      <= 1'b0;
         r_core_run   <= 1'b0;
         r_load_ready <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_ptr        <= w_ptr_next;
         r_count      <= w_count_next;
         r_error      <= w_error_next;
         r_core_run   <= (w_state_next == RUN);
         r_load_ready <= (w_state_next == LOAD);
      end
   end

   // Word array; contents survive reset, writes are blocked while reset is high.
   always_ff @(posedge Clock) begin
      if (w_we && !Reset) r_mem[r_ptr[IDX_W-1:0]] <= w_wdata;
   end

   // Combinational fetch with out-of-range NOP substitution.
   assign w_fetch_idx = InstrAddr[ADDR_W-1:2];
   assign w_fetch_ok  = (32'(w_fetch_idx) < DEPTH_WORDS);
   assign InstrMem    = w_fetch_ok ? r_mem[w_fetch_idx[IDX_W-1:0]] : NOP_WORD;

   assign LoadReady = r_load_ready;
   assign CoreRun   = r_core_run;
   assign LoadError = r_error;
   assign WordCount = r_count;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Scoreboard bench for instr_mem_ctrl: dut0 big-endian/1024 words, dut1 little-endian/4 words.
module tb_instr_mem_ctrl;

   localparam int F_MEM = 0, F_RUN = 1, F_RDY = 2, F_ERR = 3, F_CNT = 4;

   typedef struct packed {
      logic        sel;
      logic [2:0]  field;
      logic [31:0] exp;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr [2];
   logic [31:0] imem [2];
   logic [15:0] base [2];
   logic [7:0]  data [2];
   logic [15:0] wcnt [2];
   logic [1:0]  start, valid, last, ready, run, err;
   logic        probe;

   exp_t  q_exp [$];
   string q_name [$];
   int    n_cmp = 0;
   int    n_bad = 0;

   always #5 clk = ~clk;

   instr_mem_ctrl #(.ADDR_W(16), .DEPTH_WORDS(1024), .BIG_ENDIAN(1'b1), .NOP_WORD(32'h0)) u_dut0 (
      .Clock(clk), .Reset(rst), .InstrAddr(addr[0]), .InstrMem(imem[0]),
      .LoadStart(start[0]), .LoadBase(base[0]), .LoadValid(valid[0]), .LoadData(data[0]),
      .LoadLast(last[0]), .LoadReady(ready[0]), .CoreRun(run[0]), .LoadError(err[0]),
      .WordCount(wcnt[0]));

   instr_mem_ctrl #(.ADDR_W(16), .DEPTH_WORDS(4), .BIG_ENDIAN(1'b0), .NOP_WORD(32'h0)) u_dut1 (
      .Clock(clk), .Reset(rst), .InstrAddr(addr[1]), .InstrMem(imem[1]),
      .LoadStart(start[1]), .LoadBase(base[1]), .LoadValid(valid[1]), .LoadData(data[1]),
      .LoadLast(last[1]), .LoadReady(ready[1]), .CoreRun(run[1]), .LoadError(err[1]),
      .WordCount(wcnt[1]));

   function automatic logic [31:0] field_val(input logic s, input logic [2:0] f);
      case (f)
         3'd0:    return imem[s];
         3'd1:    return 32'(run[s]);
         3'd2:    return 32'(ready[s]);
         3'd3:    return 32'(err[s]);
         default: return 32'(wcnt[s]);
      endcase
   endfunction

   // Monitor: pops one expectation per probe and compares on the falling edge.
   always @(negedge clk) begin
      if (probe) begin
         n_cmp++;
         if (q_exp.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_underflow: probe with no expectation queued");
         end else begin
            exp_t        e;
            string       nm;
            logic [31:0] act;
            e   = q_exp.pop_front();
            nm  = q_name.pop_front();
            act = field_val(e.sel, e.field);
            if (act !== e.exp) begin
               n_bad++;
               $display("FAIL %s: got %h required %h", nm, act, e.exp);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input int sel, input int field, input logic [15:0] a,
                        input logic [31:0] exp, input string nm);
      exp_t e;
      e.sel   = sel[0];
      e.field = field[2:0];
      e.exp   = exp;
      addr[sel] = a;
      q_exp.push_back(e);
      q_name.push_back(nm);
      probe = 1'b1;
      @(negedge clk);
      #1 probe = 1'b0;
   endtask

   task automatic load_start(input int sel, input logic [15:0] b);
      start[sel] = 1'b1;
      base[sel]  = b;
      tick();
      start[sel] = 1'b0;
   endtask

   task automatic send(input int sel, input logic [7:0] b, input logic l);
      valid[sel] = 1'b1;
      data[sel]  = b;
      last[sel]  = l;
      tick();
      valid[sel] = 1'b0;
      last[sel]  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; probe = 1'b0;
      start = '0; valid = '0; last = '0;
      for (int i = 0; i < 2; i++) begin
         addr[i] = '0; base[i] = '0; data[i] = '0;
      end
      repeat (2) tick();
      rst = 1'b0;

      // Reset state
      check(0, F_RUN, 16'h0, 32'd0, "rst_corerun");
      check(0, F_RDY, 16'h0, 32'd0, "rst_loadready");
      check(0, F_ERR, 16'h0, 32'd0, "rst_loaderror");
      check(0, F_CNT, 16'h0, 32'd0, "rst_wordcount");
      check(1, F_RUN, 16'h0, 32'd0, "rst_corerun_le");

      // Single big-endian word
      load_start(0, 16'h0000);
      check(0, F_RDY, 16'h0, 32'd1, "load_ready");
      send(0, 8'h12, 1'b0); send(0, 8'h34, 1'b0); send(0, 8'h56, 1'b0); send(0, 8'h78, 1'b1);
      check(0, F_RUN, 16'h0000, 32'd1, "be_run");
      check(0, F_CNT, 16'h0000, 32'd1, "be_count");
      check(0, F_MEM, 16'h0000, 32'h12345678, "be_word");
      check(0, F_MEM, 16'h0002, 32'h12345678, "be_word_lowbits");
      check(0, F_MEM, 16'h1000, 32'h00000000, "be_nop_out_of_range");

      // Six bytes with flush of a partial word
      load_start(0, 16'h0010);
      check(0, F_RUN, 16'h0, 32'd0, "run_drop_after_start");
      send(0, 8'hAA, 1'b0); send(0, 8'hBB, 1'b0); send(0, 8'hCC, 1'b0);
      send(0, 8'hDD, 1'b0); send(0, 8'hEE, 1'b0); send(0, 8'hFF, 1'b1);
      check(0, F_RUN, 16'h0, 32'd0, "flush_cycle_norun");
      check(0, F_RUN, 16'h0, 32'd1, "flush_then_run");
      check(0, F_CNT, 16'h0, 32'd2, "flush_count");
      check(0, F_MEM, 16'h0010, 32'hAABBCCDD, "flush_word0");
      check(0, F_MEM, 16'h0014, 32'hEEFF0000, "flush_word1");

      // Mid-word restart drops the same-cycle byte; LoadLast without LoadValid is ignored
      load_start(0, 16'h0020);
      send(0, 8'h11, 1'b0); send(0, 8'h22, 1'b0);
      start[0] = 1'b1; base[0] = 16'h0030; valid[0] = 1'b1; data[0] = 8'h99;
      tick();
      start[0] = 1'b0; valid[0] = 1'b0;
      send(0, 8'h01, 1'b0); send(0, 8'h02, 1'b0); send(0, 8'h03, 1'b0); send(0, 8'h04, 1'b0);
      last[0] = 1'b1;
      tick();
      last[0] = 1'b0;
      check(0, F_RDY, 16'h0, 32'd1, "last_without_valid_ignored");
      send(0, 8'h05, 1'b0); send(0, 8'h06, 1'b0); send(0, 8'h07, 1'b0); send(0, 8'h08, 1'b1);
      check(0, F_RUN, 16'h0, 32'd1, "restart_run");
      check(0, F_CNT, 16'h0, 32'd2, "restart_count");
      check(0, F_MEM, 16'h0030, 32'h01020304, "restart_word0");
      check(0, F_MEM, 16'h0034, 32'h05060708, "restart_word1");

      // Little-endian word, then overflow of a 4-word array
      load_start(1, 16'h0000);
      send(1, 8'h12, 1'b0); send(1, 8'h34, 1'b0); send(1, 8'h56, 1'b0); send(1, 8'h78, 1'b1);
      check(1, F_RUN, 16'h0000, 32'd1, "le_run");
      check(1, F_MEM, 16'h0000, 32'h78563412, "le_word");
      load_start(1, 16'h000C);
      for (int i = 1; i <= 8; i++) send(1, 8'(i), (i == 8));
      check(1, F_ERR, 16'h0, 32'd1, "ovf_error");
      check(1, F_CNT, 16'h0, 32'd1, "ovf_count");
      check(1, F_RUN, 16'h0, 32'd0, "ovf_norun");
      check(1, F_RDY, 16'h0, 32'd0, "ovf_idle_notready");
      check(1, F_MEM, 16'h000C, 32'h04030201, "ovf_word3");
      check(1, F_MEM, 16'h0010, 32'h00000000, "ovf_nop");
      check(1, F_MEM, 16'h0000, 32'h78563412, "ovf_word0_kept");

      // Reset mid-load abandons the partial word
      load_start(0, 16'h0000);
      send(0, 8'hAB, 1'b0); send(0, 8'hCD, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check(0, F_RUN, 16'h0, 32'd0, "midrst_corerun");
      check(0, F_RDY, 16'h0, 32'd0, "midrst_loadready");
      check(0, F_CNT, 16'h0, 32'd0, "midrst_count");
      check(0, F_MEM, 16'h0000, 32'h12345678, "midrst_word0_kept");
      check(0, F_MEM, 16'h0010, 32'hAABBCCDD, "midrst_word4_kept");
      check(1, F_ERR, 16'h0, 32'd0, "midrst_error_cleared");
      check(1, F_MEM, 16'h000C, 32'h04030201, "midrst_le_word_kept");

      tick();
      if (q_exp.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_leftover: got %0d pending required 0", q_exp.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
- Responder end of the instruction-fetch interface.
- Serves 32-bit instructions to the IF stage from an on-chip word array. IF drives InstrAddr and receives InstrMem in the same cycle.
- A byte-stream loader FSM fills the array before execution. CoreRun gates the core (drive the core's nReset from CoreRun) until a load completes.

Parameters:
- ADDR_W, 16, width of the fetch/load byte address.
- DEPTH_WORDS, 1024, number of 32-bit words in the array.
- BIG_ENDIAN, 1, 1: first byte of a word lands in [31:24]; 0: first byte lands in [7:0].
- NOP_WORD, 32'h00000000, value returned for out-of-range fetch.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- InstrAddr  in  ADDR_W  fetch byte address from IF.
- InstrMem  out  32  fetched instruction to IF.
- LoadStart  in  1  pulse: begin a load at LoadBase.
- LoadBase  in  ADDR_W  load start byte address; bits [1:0] are ignored.
- LoadValid  in  1  LoadData is valid.
- LoadData  in  8  load byte.
- LoadLast  in  1  qualifies the final byte of the image (valid with LoadValid).
- LoadReady  out  1  the loader accepts a byte this cycle.
- CoreRun  out  1  array is stable and the core may execute.
- LoadError  out  1  sticky: the load overran DEPTH_WORDS.
- WordCount  out  16  words committed by the current/last load.

Behaviour:
- One clock domain: Clock. Reset is synchronous and active-high.
- Reset values: CoreRun=0, LoadReady=0, LoadError=0, WordCount=0, FSM=IDLE, byte index=0. Array contents are not cleared. Reset during a load abandons the load and discards any partial word.
- Fetch path:
  - Combinational read. Word index = InstrAddr[ADDR_W-1:2]; InstrAddr[1:0] is ignored.
  - Index >= DEPTH_WORDS returns NOP_WORD.
  - A write at edge N is visible to a fetch in cycle N+1.
- FSM states:
  - IDLE: CoreRun=0, LoadReady=0. LoadStart -> LOAD.
  - LOAD: LoadReady=1. A byte is accepted when LoadValid && LoadReady.
    - Bytes are assembled into a shift register and a 2-bit index counts them.
    - On the 4th byte the word is written at the word pointer, the pointer increments, WordCount increments, and the index wraps to 0.
    - LoadLast with the index at 3 -> RUN. LoadLast with the index < 3 -> FLUSH.
  - FLUSH: one cycle, LoadReady=0. The partial word is written with its remaining bytes zero-filled, WordCount increments -> RUN.
  - RUN: CoreRun=1, LoadReady=0. LoadStart -> LOAD, and CoreRun drops the next cycle.
- On entry to LOAD (from any state): word pointer = LoadBase[ADDR_W-1:2], index=0, WordCount=0, LoadError=0.
- LoadStart while in LOAD: restart at the new LoadBase. A same-cycle LoadValid byte is dropped and any partial word is discarded.
- Overflow:
  - A write with pointer >= DEPTH_WORDS is suppressed and sets LoadError. WordCount does not increment.
  - Bytes keep being accepted and dropped until LoadLast.
  - The final transition goes to IDLE instead of RUN when LoadError=1.
- LoadLast without LoadValid is ignored.
- Word pointer wrap at 2^(ADDR_W-2) is not possible: overflow is detected first.

Decomposition:
- Package instr_mem_pkg: loader state enum (IDLE, LOAD, FLUSH, RUN) and the NOP constant.
- One sub-module: instr_word_assembler (byte index counter, endian-aware shift register, word_done/flush outputs). The FSM and the array stay in the top module.

Test Plan:
- Reset -> CoreRun=0, LoadReady=0, LoadError=0, WordCount=0. LoadStart with LoadBase=16'h0000, then bytes 12 34 56 78 with LoadLast on 78 (BIG_ENDIAN=1) -> RUN, WordCount=1, InstrAddr=16'h0000 returns 32'h12345678, InstrAddr=16'h0002 returns the same word.
- Six bytes AA BB CC DD EE FF with LoadLast on FF, LoadBase=16'h0010 -> FLUSH for one cycle, then RUN. Addr 16'h0010 returns 32'hAABBCCDD, addr 16'h0014 returns 32'hEEFF0000, WordCount=2.
- BIG_ENDIAN=0 with bytes 12 34 56 78 -> returns 32'h78563412.
- DEPTH_WORDS=4, LoadBase=16'h000C, 8 bytes -> first word written at index 3, LoadError=1, WordCount=1, FSM ends in IDLE, CoreRun stays 0. Fetch at 16'h0010 returns 32'h00000000.
- In RUN, LoadStart -> CoreRun=0 the next cycle. Mid-word (2 bytes in), a second LoadStart with LoadValid set -> the same-cycle byte is dropped and a reload at the new base produces clean words.
- Reset asserted after 2 bytes of a load -> IDLE, the partial word is never written, and the previously loaded array contents are unchanged on fetch.
